sdr_wb_arbiter: RTL and testbench

- Round-robin Wishbone B.3 arbiter that lets NUM_M bus masters share the single Wishbone slave port of the SDRAM controller.
- Lives in the wb_clk_i domain, between the masters and the controller's wb_* inputs.
- Holds a grant for a whole bus cycle (CYC_O), never for a single strobe.
- Guarantees at least one CYC-low cycle between owners.
- Reports stalled transfers to the owning master through a per-master error pulse (watchdog).

---
 rtl/sdr_wb_arbiter_if.sv | 39 +++
 rtl/sdr_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_sdr_wb_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sdr_wb_arbiter_if.sv
// Wishbone bus bundle between NUM_M masters, the round-robin arbiter and the
// single SDRAM-controller slave port.
//   m_*_i / m_*_o : per-master request and response signals, packed per master
//                   (master k uses slice [k*W +: W]); m_dat_o is a broadcast
//   s_*_o / s_*_i : the single Wishbone port toward the SDRAM controller
// Modports:
//   slave  : the arbiter's view of the bus
//   master : the environment's view (the masters plus the SDRAM slave)
interface sdr_wb_arbiter_if #(
  parameter int NUM_M = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int SELW = DW / 8;

  logic [NUM_M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0]   m_adr_i;
  logic [NUM_M*DW-1:0]   m_dat_i;
  logic [NUM_M*SELW-1:0] m_sel_i;
  logic [NUM_M-1:0]      m_ack_o, m_err_o;
  logic [DW-1:0]         m_dat_o;

  logic                  s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]         s_adr_o;
  logic [DW-1:0]         s_dat_o;
  logic [SELW-1:0]       s_sel_o;
  logic                  s_ack_i;
  logic [DW-1:0]         s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/sdr_wb_arbiter.sv
// Round-robin Wishbone B.3 arbiter: NUM_M masters share the SDRAM controller's
// single slave port. A grant covers a whole CYC bus cycle, and every hand-over
// passes through IDLE so the slave always sees at least one CYC-low cycle
// between owners. A watchdog flags strobes left unacknowledged for TIMEOUT
// cycles with a one-cycle error pulse to the owner (the grant is kept).
// Ports:
//   wb_clk_i  Wishbone clock (only clock)
//   wb_rst_i  synchronous active-high reset
//   bus       sdr_wb_arbiter_if.slave (master requests, slave port, acks/errors)
//   gnt_o     registered one-hot grant
//   busy_o    high while a master owns the bus
module sdr_wb_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  sdr_wb_arbiter_if.slave      bus,
  output logic [NUM_M-1:0]     gnt_o,
  output logic                 busy_o
);
  localparam int SELW = DW / 8;
  localparam int IW   = $clog2(NUM_M);
  localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NUM_M-1:0] ONE = NUM_M'(1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q;
  logic [NUM_M-1:0] gnt_q;
  logic [IW-1:0]    last_q;   // previous winner; search starts just above it
  logic [IW-1:0]    own_q;    // index of current owner
  logic [WDW-1:0]   wd_q;
  logic [NUM_M-1:0] err_q;

  logic [IW-1:0]    win_d;
  logic             found;
  int               idx;

  // First requester strictly above last_q, wrapping; last_q itself is checked
  // last, so a master re-requesting right away loses to anyone else pending.
  always_comb begin
    win_d = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = (int'(last_q) + i) % NUM_M;
      if (!found && bus.m_cyc_i[idx]) begin
        found = 1'b1;
        win_d = IW'(idx);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_M - 1);
      own_q   <= '0;
      wd_q    <= '0;
      err_q   <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (found) begin
            state_q <= OWN;
            gnt_q   <= ONE << win_d;
            last_q  <= win_d;
            own_q   <= win_d;
          end
        end
        OWN: begin
          if (!bus.m_cyc_i[own_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            wd_q    <= '0;
          end else if (TIMEOUT > 0 && bus.m_stb_i[own_q] && !bus.s_ack_i) begin
            // Pulse is registered, so it shows in the cycle after the
            // TIMEOUT-th stalled edge; counter restarts for the next period.
            if (wd_q == WDW'(TIMEOUT - 1)) begin
              wd_q         <= '0;
              err_q[own_q] <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end else begin
            wd_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset masks the slave-facing handshakes immediately, not one edge later.
  logic own;
  assign own = (state_q == OWN) && !wb_rst_i;

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_ack_o = '0;
    if (own) begin
      bus.s_cyc_o        = bus.m_cyc_i[own_q];
      bus.s_stb_o        = bus.m_stb_i[own_q];
      bus.s_we_o         = bus.m_we_i[own_q];
      bus.s_adr_o        = bus.m_adr_i[own_q*AW +: AW];
      bus.s_dat_o        = bus.m_dat_i[own_q*DW +: DW];
      bus.s_sel_o        = bus.m_sel_i[own_q*SELW +: SELW];
      // Gating with STB drops stray ACKs seen while the owner is idle.
      bus.m_ack_o[own_q] = bus.s_ack_i & bus.m_stb_i[own_q];
    end
  end

  assign bus.m_err_o = wb_rst_i ? '0 : err_q;
  assign bus.m_dat_o = bus.s_dat_i;
  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q == OWN);
endmodule

// File: tb/tb_sdr_wb_arbiter.sv
module tb_sdr_wb_arbiter;
  localparam int NUM_M = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_M-1:0] gnt;
  logic busy;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdr_wb_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

  sdr_wb_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(8)) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .gnt_o    (gnt),
    .busy_o   (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
  endtask

  task automatic do_reset;
    clr();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[k] = cyc; bus.m_stb_i[k] = stb; bus.m_we_i[k] = we;
    bus.m_adr_i[k*AW +: AW] = adr;
    bus.m_dat_i[k*DW +: DW] = dat;
    bus.m_sel_i[k*4 +: 4]   = 4'hF;
  endtask

  task automatic test_reset;
    clr();
    bus.m_cyc_i = 4'hF; bus.m_stb_i = 4'hF; bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h1234_5678;
    rst = 1'b1;
    step();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_scyc got=%b%b exp=00", bus.s_cyc_o, bus.s_stb_o); end
    checks++; if (bus.m_ack_o !== 4'b0000 || bus.m_err_o !== 4'b0000) begin failures++; $display("FAIL reset_ackerr got=%b/%b exp=0000/0000", bus.m_ack_o, bus.m_err_o); end
    checks++; if (bus.m_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL reset_mdat got=%h exp=12345678", bus.m_dat_o); end
    step();
    checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b/%b exp=0000/0", gnt, bus.s_cyc_o); end
    rst = 1'b0;
    clr();
  endtask

  task automatic test_single;
    do_reset();
    set_m(1, 1, 1, 1, 32'h100, 32'hDEAD_BEEF);
    #1;
    checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_pre got=%b/%b exp=0000/0", gnt, bus.s_cyc_o); end
    step();
    checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL single_gnt got=%b/%b exp=0010/1", gnt, busy); end
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1) begin failures++; $display("FAIL single_ctl got=%b%b%b exp=111", bus.s_cyc_o, bus.s_stb_o, bus.s_we_o); end
    checks++; if (bus.s_adr_o !== 32'h100 || bus.s_dat_o !== 32'hDEAD_BEEF || bus.s_sel_o !== 4'hF) begin failures++; $display("FAIL single_bus got=%h/%h/%h exp=00000100/deadbeef/f", bus.s_adr_o, bus.s_dat_o, bus.s_sel_o); end
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.m_ack_o !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", bus.m_ack_o); end
    step();
    bus.s_ack_i = 1'b0;
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.m_ack_o !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_rel got=%b/%b exp=0000/0", bus.m_ack_o, bus.s_cyc_o); end
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_drop got=%b/%b exp=0000/0", gnt, busy); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    set_m(0, 1, 1, 0, 32'h0, 32'h0);
    set_m(2, 1, 1, 0, 32'h2, 32'h0);
    set_m(3, 1, 1, 0, 32'h3, 32'h0);
    step();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL simul_first got=%b exp=0001", gnt); end
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL simul_gap1 got=%b/%b exp=0000/0", gnt, bus.s_cyc_o); end
    step();
    checks++; if (gnt !== 4'b0100 || bus.s_adr_o !== 32'h2) begin failures++; $display("FAIL simul_second got=%b/%h exp=0100/2", gnt, bus.s_adr_o); end
    set_m(0, 1, 1, 0, 32'h0, 32'h0);
    set_m(2, 0, 0, 0, 32'h0, 32'h0);
    step();
    checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL simul_gap2 got=%b/%b exp=0000/0", gnt, bus.s_cyc_o); end
    step();
    checks++; if (gnt !== 4'b1000 || bus.s_adr_o !== 32'h3) begin failures++; $display("FAIL simul_third got=%b/%h exp=1000/3", gnt, bus.s_adr_o); end
    set_m(3, 0, 0, 0, 32'h0, 32'h0);
    step();
    checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL simul_gap3 got=%b/%b exp=0000/0", gnt, bus.s_cyc_o); end
    step();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL simul_again got=%b exp=0001", gnt); end
    clr();
    step(); step();
  endtask

  task automatic test_hold;
    logic [31:0] beat [4];
    beat[0] = 32'hA0A0_0001; beat[1] = 32'hB1B1_0002;
    beat[2] = 32'hC2C2_0003; beat[3] = 32'hD3D3_0004;
    do_reset();
    set_m(2, 1, 0, 0, 32'h200, 32'h0);
    step();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL hold_gnt got=%b exp=0100", gnt); end
    set_m(0, 1, 1, 0, 32'h0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      bus.m_stb_i[2] = 1'b1;
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = beat[b];
      #1;
      checks++; if (bus.m_ack_o !== 4'b0100 || bus.m_dat_o !== beat[b]) begin failures++; $display("FAIL hold_beat%0d got=%b/%h exp=0100/%h", b, bus.m_ack_o, bus.m_dat_o, beat[b]); end
      step();
      bus.m_stb_i[2] = 1'b0;
      bus.s_ack_i = 1'b0;
      step(); step();
      checks++; if (gnt !== 4'b0100 || bus.s_cyc_o !== 1'b1) begin failures++; $display("FAIL hold_keep%0d got=%b/%b exp=0100/1", b, gnt, bus.s_cyc_o); end
    end
    set_m(2, 0, 0, 0, 32'h0, 32'h0);
    step();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL hold_rel got=%b exp=0000", gnt); end
    step();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL hold_next got=%b exp=0001", gnt); end
    clr();
    step(); step();
  endtask

  task automatic test_watchdog;
    logic [3:0] exp_err;
    do_reset();
    set_m(3, 1, 1, 0, 32'h300, 32'h0);
    step();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL wd_gnt got=%b exp=1000", gnt); end
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_err = (i == 8 || i == 16) ? 4'b1000 : 4'b0000;
      checks++; if (bus.m_err_o !== exp_err || gnt !== 4'b1000) begin failures++; $display("FAIL wd_cycle%0d got=%b/%b exp=%b/1000", i, bus.m_err_o, gnt, exp_err); end
    end
    set_m(3, 0, 0, 0, 32'h0, 32'h0);
    step(); step();
    checks++; if (gnt !== 4'b0000 || bus.m_err_o !== 4'b0000) begin failures++; $display("FAIL wd_end got=%b/%b exp=0000/0000", gnt, bus.m_err_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_m(1, 1, 1, 1, 32'h140, 32'h0);
    step();
    checks++; if (gnt !== 4'b0010 || bus.s_cyc_o !== 1'b1) begin failures++; $display("FAIL rmid_own got=%b/%b exp=0010/1", gnt, bus.s_cyc_o); end
    set_m(0, 1, 1, 0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL rmid_during got=%b%b/%b exp=00/0000", bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o); end
    step();
    rst = 1'b0;
    bus.s_ack_i = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b/%b exp=0000/0", gnt, bus.s_cyc_o); end
    step();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_first got=%b exp=0001", gnt); end
    clr();
    step(); step();
  endtask

  task automatic test_stray_ack;
    do_reset();
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL stray_idle got=%b exp=0000", bus.m_ack_o); end
    bus.s_ack_i = 1'b0;
    set_m(1, 1, 0, 0, 32'h180, 32'h0);
    step();
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0010 || bus.s_stb_o !== 1'b0 || bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL stray_own got=%b/%b/%b exp=0010/0/0000", gnt, bus.s_stb_o, bus.m_ack_o); end
    step();
    checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL stray_own2 got=%b exp=0000", bus.m_ack_o); end
    clr();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_hold();
    test_watchdog();
    test_reset_mid();
    test_stray_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
